// File: rtl/fb_pkg.sv
// Framebuffer geometry and arbiter state shared by the drawing blocks.
package fb_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 19;

  typedef enum logic {ARB, CLEAR} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Owns the framebuffer write port: round-robin requesters plus a full-screen clear sweep.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 19,
  parameter int FB_PIXELS = 307200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  input  logic                      clear_value,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      err_oob,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic                      fb_data
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FB_PIXELS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FB_PIXELS - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              val_q, val_d;
  logic              we_q, we_d, data_q, data_d, err_q, err_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_data, xfer;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid), .ptr(ptr_q), .grant(grant), .grant_idx(gidx)
  );

  assign req_ready = (state_q == ARB && !clear_start) ? grant : '0;
  assign xfer      = |(req_ready & req_valid);
  assign sel_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gidx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ARB: begin
        // busy still high means the final sweep write went out last cycle
        done_d = busy_q;
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          val_d   = clear_value;
        end else if (xfer) begin
          ptr_d  = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
          addr_d = sel_addr;
          data_d = sel_data;
          we_d   = (sel_addr < LIMIT);
          err_d  = (sel_addr >= LIMIT);
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = val_q;
        busy_d = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign err_oob    = err_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a cycle-level behavioural model.
module tb_fb_write_arbiter;
  localparam int NR = 3;
  localparam int AW = 19;
  localparam int P  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_data, req_ready;
  logic [NR*AW-1:0] req_addr;
  logic clear_start, clear_value, clear_busy, clear_done, err_oob, fb_we, fb_data;
  logic [AW-1:0] fb_addr;

  fb_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .FB_PIXELS(P)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
    .clear_value(clear_value), .clear_busy(clear_busy), .clear_done(clear_done),
    .err_oob(err_oob), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model state
  int m_ptr, m_cnt;
  bit m_clr, m_val;
  bit e_we, e_data, e_err, e_busy, e_done;
  int e_addr;
  // requester pending transactions
  bit pv[NR];
  int pa[NR];
  bit pd[NR];
  int mode, clr_wr, done_seen;
  int glog[$];

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pv[i];
      req_addr[i*AW +: AW] = AW'(pa[i]);
      req_data[i] = pd[i];
    end
  endtask

  function automatic int winner();
    if (m_clr || clear_start) return -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (pv[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_clr = 0; m_val = 0;
    e_we = 0; e_data = 0; e_err = 0; e_busy = 0; e_done = 0; e_addr = 0;
  endtask

  task automatic step();
    int w;
    logic [31:0] er;
    apply();
    @(negedge clk);
    w  = winner();
    er = (w >= 0) ? (32'd1 << w) : 32'd0;
    chk("req_ready", {29'd0, req_ready}, er);
    @(posedge clk);
    if (m_clr) begin
      e_done = 0; e_we = 1; e_addr = m_cnt; e_data = m_val; e_err = 0; e_busy = 1;
      if (m_cnt == P - 1) m_clr = 0;
      m_cnt++;
    end else begin
      e_done = e_busy; e_busy = 0; e_we = 0; e_err = 0;
      if (clear_start) begin
        m_clr = 1; m_cnt = 0; m_val = clear_value;
      end else if (w >= 0) begin
        glog.push_back(w);
        m_ptr = (w + 1) % NR;
        if (pa[w] < P) begin
          e_we = 1; e_addr = pa[w]; e_data = pd[w];
        end else e_err = 1;
        pv[w] = 0;
      end
    end
    #1;
    chk("fb_we", {31'd0, fb_we}, {31'd0, e_we});
    chk("err_oob", {31'd0, err_oob}, {31'd0, e_err});
    chk("clear_busy", {31'd0, clear_busy}, {31'd0, e_busy});
    chk("clear_done", {31'd0, clear_done}, {31'd0, e_done});
    if (e_we) begin
      chk("fb_addr", {13'd0, fb_addr}, e_addr);
      chk("fb_data", {31'd0, fb_data}, {31'd0, e_data});
    end
    if (fb_we && clear_busy) clr_wr++;
    if (clear_done) done_seen++;
    clear_start = 0;
    if (mode == 1) begin
      pv[0] = 1; pa[0] = 10; pd[0] = 1;
      pv[1] = 1; pa[1] = 20; pd[1] = 0;
    end else if (mode == 2) begin
      for (int i = 0; i < NR; i++)
        if (!pv[i] && ($urandom % 3 == 0)) begin
          pv[i] = 1;
          pa[i] = ($urandom % 8 == 0) ? P + int'($urandom % 100) : int'($urandom % P);
          pd[i] = 1'($urandom);
        end
      clear_start = ($urandom % 400 == 0);
      clear_value = 1'($urandom);
    end
  endtask

  task automatic clr_pending();
    for (int i = 0; i < NR; i++) begin pv[i] = 0; pa[i] = 0; pd[i] = 0; end
  endtask

  initial begin
    clear_start = 0; clear_value = 0; mode = 0; clr_wr = 0; done_seen = 0;
    clr_pending(); apply(); model_reset();
    #1;
    chk("rst_fb_we", {31'd0, fb_we}, 0);
    chk("rst_fb_addr", {13'd0, fb_addr}, 0);
    chk("rst_busy", {31'd0, clear_busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) step();

    // fairness: two requesters hold valid continuously
    mode = 1; glog.delete();
    pv[0] = 1; pa[0] = 10; pd[0] = 1; pv[1] = 1; pa[1] = 20; pd[1] = 0;
    repeat (8) step();
    for (int i = 0; i < 4; i++) chk("rr_order", glog[i], i % 2);
    mode = 0; clr_pending();
    repeat (2) step();

    // clear beats a simultaneous request, then the request is served
    pv[0] = 1; pa[0] = 5; pd[0] = 1;
    clear_start = 1; clear_value = 1; clr_wr = 0; done_seen = 0;
    repeat (P + 4) step();
    chk("clear_writes", clr_wr, P);
    chk("clear_done_cnt", done_seen, 1);
    chk("req0_served", {31'd0, pv[0]}, 0);

    // out-of-range address
    pv[1] = 1; pa[1] = P; pd[1] = 1;
    repeat (3) step();

    // reset mid-clear
    clear_start = 1; clear_value = 1;
    repeat (1001) step();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("abort_we", {31'd0, fb_we}, 0);
    chk("abort_addr", {13'd0, fb_addr}, 0);
    chk("abort_data", {31'd0, fb_data}, 0);
    chk("abort_busy", {31'd0, clear_busy}, 0);
    @(negedge clk); rst_n = 1;
    done_seen = 0;
    repeat (4) step();
    chk("abort_no_done", done_seen, 0);
    clear_start = 1; clear_value = 0; clr_wr = 0;
    step();
    chk("restart_addr0", {13'd0, fb_addr}, 0);
    repeat (P + 3) step();
    chk("restart_writes", clr_wr, P);

    // clear_start repeated during sweep is ignored
    clear_start = 1; clear_value = 1; clr_wr = 0; done_seen = 0;
    repeat (51) step();
    clear_start = 1;
    repeat (P + 5) step();
    chk("reclear_writes", clr_wr, P);
    chk("reclear_done", done_seen, 1);

    // randomized traffic
    mode = 2;
    repeat (8000) step();
    mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
